// File: rtl/ihex_record_tx.sv
`default_nettype none
// ============================================================================
// ihex_record_tx : buffers payload bytes, then serialises one Intel HEX record
// (":LLAAAATT<data>CC" CR LF) character by character into a uart_tx port.
// Revision: 1.0
// ============================================================================
module ihex_record_tx #(
  parameter int MAX_LEN = 16,
  parameter int CW      = $clog2(MAX_LEN + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr,
  input  logic [7:0]    i_wr_data,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  input  logic          i_start,
  input  logic [15:0]   i_addr,
  input  logic [7:0]    i_type,
  output logic          o_busy,
  output logic          o_done,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_stb,
  input  logic          i_tx_busy
);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_COLON, S_LEN, S_ADDR, S_TYPE, S_DATA, S_CSUM, S_CR, S_LF
  } state_t;

  state_t        state_q, state_d;
  logic          nib_q, nib_d;
  logic [1:0]    aidx_q, aidx_d;
  logic [7:0]    bidx_q, bidx_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    type_q, type_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    csum_q, csum_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tx_stb_q, tx_stb_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          mem_we;
  logic          can_send;
  logic [7:0]    data_byte;
  logic [7:0]    cc;
  logic [7:0]    mem_q [MAX_LEN];

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction

  assign data_byte = mem_q[bidx_q[AW-1:0]];
  assign cc        = 8'h00 - csum_q;

  always_comb begin
    state_d   = state_q;
    nib_d     = nib_q;
    aidx_d    = aidx_q;
    bidx_d    = bidx_q;
    addr_d    = addr_q;
    type_d    = type_q;
    len_d     = len_q;
    csum_d    = csum_q;
    count_d   = count_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tx_stb_d  = 1'b0;
    tx_data_d = tx_data_q;
    mem_we    = 1'b0;
    // The cycle right after a strobe is the guard cycle: uart_tx has not yet raised busy.
    can_send  = !i_tx_busy && !tx_stb_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          addr_d  = i_addr;
          type_d  = i_type;
          len_d   = 8'(count_q);
          csum_d  = 8'h00;
          nib_d   = 1'b0;
          aidx_d  = 2'd0;
          bidx_d  = 8'd0;
          busy_d  = 1'b1;
          state_d = S_COLON;
        end else if (i_wr && !full_q) begin
          mem_we  = 1'b1;
          count_d = count_q + CW'(1);
        end
      end
      S_COLON: if (can_send) begin
        tx_stb_d  = 1'b1;
        tx_data_d = 8'h3A;
        state_d   = S_LEN;
      end
      S_LEN: if (can_send) begin
        tx_stb_d  = 1'b1;
        tx_data_d = hex_char(nib_q ? len_q[3:0] : len_q[7:4]);
        if (!nib_q) csum_d = csum_q + len_q;
        nib_d = !nib_q;
        if (nib_q) state_d = S_ADDR;
      end
      S_ADDR: if (can_send) begin
        tx_stb_d  = 1'b1;
        tx_data_d = hex_char(addr_q[{~aidx_q, 2'b00} +: 4]);
        // Even nibble indices start a byte: 0 -> addr[15:8], 2 -> addr[7:0].
        if (!aidx_q[0]) csum_d = csum_q + addr_q[{~aidx_q[1], 3'b000} +: 8];
        aidx_d = aidx_q + 2'd1;
        if (aidx_q == 2'd3) state_d = S_TYPE;
      end
      S_TYPE: if (can_send) begin
        tx_stb_d  = 1'b1;
        tx_data_d = hex_char(nib_q ? type_q[3:0] : type_q[7:4]);
        if (!nib_q) csum_d = csum_q + type_q;
        nib_d = !nib_q;
        if (nib_q) state_d = (len_q == 8'd0) ? S_CSUM : S_DATA;
      end
      S_DATA: if (can_send) begin
        tx_stb_d  = 1'b1;
        tx_data_d = hex_char(nib_q ? data_byte[3:0] : data_byte[7:4]);
        if (!nib_q) csum_d = csum_q + data_byte;
        nib_d = !nib_q;
        if (nib_q) begin
          bidx_d = bidx_q + 8'd1;
          if (bidx_q + 8'd1 == len_q) state_d = S_CSUM;
        end
      end
      S_CSUM: if (can_send) begin
        tx_stb_d  = 1'b1;
        tx_data_d = hex_char(nib_q ? cc[3:0] : cc[7:4]);
        nib_d = !nib_q;
        if (nib_q) state_d = S_CR;
      end
      S_CR: if (can_send) begin
        tx_stb_d  = 1'b1;
        tx_data_d = 8'h0D;
        state_d   = S_LF;
      end
      S_LF: begin
        // nib_q marks that LF has gone out; finish on the following cycle.
        if (nib_q) begin
          nib_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          count_d = '0;
          state_d = S_IDLE;
        end else if (can_send) begin
          tx_stb_d  = 1'b1;
          tx_data_d = 8'h0A;
          nib_d     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    full_d = (count_d == CW'(MAX_LEN));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      nib_q     <= 1'b0;
      aidx_q    <= 2'd0;
      bidx_q    <= 8'd0;
      addr_q    <= 16'h0000;
      type_q    <= 8'h00;
      len_q     <= 8'h00;
      csum_q    <= 8'h00;
      count_q   <= '0;
      full_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tx_stb_q  <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      nib_q     <= nib_d;
      aidx_q    <= aidx_d;
      bidx_q    <= bidx_d;
      addr_q    <= addr_d;
      type_q    <= type_d;
      len_q     <= len_d;
      csum_q    <= csum_d;
      count_q   <= count_d;
      full_q    <= full_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tx_stb_q  <= tx_stb_d;
      tx_data_q <= tx_data_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) mem_q[count_q[AW-1:0]] <= i_wr_data;
  end

  assign o_count   = count_q;
  assign o_full    = full_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_tx_stb  = tx_stb_q;
  assign o_tx_data = tx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ihex_record_tx.sv
`default_nettype none
// Bench for ihex_record_tx: a small uart_tx busy model, a character monitor and
// a string-level Intel HEX record model built from queues.
module tb_ihex_record_tx;
  localparam int MAX_LEN = 16;
  localparam int CW      = $clog2(MAX_LEN + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          start = 1'b0;
  logic [15:0]   addr = 16'h0000;
  logic [7:0]    typ = 8'h00;
  logic [CW-1:0] count;
  logic          full, busy, done, tx_stb, tx_busy;
  logic [7:0]    tx_data;

  int   n_checks = 0;
  int   n_errors = 0;
  int   ucnt = 0;
  int   uart_bits = 0;
  logic force_busy = 1'b0;
  int   stb_cnt = 0;
  int   done_cnt = 0;
  int   adj_cnt = 0;
  logic prev_stb = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] model_buf[$];

  ihex_record_tx #(.MAX_LEN(MAX_LEN)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr(wr), .i_wr_data(wr_data),
    .o_count(count), .o_full(full), .i_start(start), .i_addr(addr),
    .i_type(typ), .o_busy(busy), .o_done(done), .o_tx_data(tx_data),
    .o_tx_stb(tx_stb), .i_tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: busy for uart_bits cycles after it samples a strobe.
  assign tx_busy = force_busy || (ucnt != 0);
  always @(posedge clk) begin
    if (tx_stb) ucnt <= uart_bits;
    else if (ucnt != 0) ucnt <= ucnt - 1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_stb) begin
        rx_q.push_back(tx_data);
        stb_cnt++;
        if (prev_stb) adj_cnt++;
      end
      if (done) done_cnt++;
    end
    prev_stb = tx_stb;
  end

  function automatic logic [7:0] hexc(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  task automatic push_hex(input int b);
    exp_q.push_back(hexc(b / 16));
    exp_q.push_back(hexc(b % 16));
  endtask

  // Record text from its fields; checksum is the two's complement of the byte sum.
  task automatic build(input logic [15:0] a, input logic [7:0] t);
    int sum;
    exp_q = {};
    exp_q.push_back(8'h3A);
    sum = model_buf.size() + int'(a) / 256 + int'(a) % 256 + int'(t);
    push_hex(model_buf.size());
    push_hex(int'(a) / 256);
    push_hex(int'(a) % 256);
    push_hex(int'(t));
    foreach (model_buf[i]) begin
      push_hex(int'(model_buf[i]));
      sum += int'(model_buf[i]);
    end
    push_hex((256 - sum % 256) % 256);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic load_str(input string s);
    exp_q = {};
    for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk); wr = 1'b1; wr_data = b;
    @(negedge clk); wr = 1'b0;
    if (model_buf.size() < MAX_LEN) model_buf.push_back(b);
  endtask

  task automatic pulse_start(input logic [15:0] a, input logic [7:0] t);
    rx_q = {};
    done_cnt = 0;
    adj_cnt = 0;
    @(negedge clk); start = 1'b1; addr = a; typ = t;
    @(negedge clk); start = 1'b0;
    model_buf = {};
  endtask

  // Waits for o_done (bounded) then reports the first differing character.
  task automatic wait_record(output int bad, output logic [7:0] got_c, output logic [7:0] exp_c);
    for (int i = 0; i < 5000 && done_cnt == 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    bad = -1; got_c = 8'h00; exp_c = 8'h00;
    for (int i = 0; i < exp_q.size() || i < rx_q.size(); i++) begin
      if (i >= rx_q.size() || i >= exp_q.size() || rx_q[i] !== exp_q[i]) begin
        bad = i;
        got_c = (i < rx_q.size()) ? rx_q[i] : 8'hXX;
        exp_c = (i < exp_q.size()) ? exp_q[i] : 8'hXX;
        break;
      end
    end
  endtask

  task automatic wait_strobes(input int n);
    int base;
    base = stb_cnt;
    for (int i = 0; i < 3000 && stb_cnt < base + n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx_stb, tx_data, busy, done, count, full} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got stb=%b data=%h busy=%b done=%b count=%0d full=%b, need all zero",
               tx_stb, tx_data, busy, done, count, full);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx_stb, busy, done, count, full} !== '0) begin
      n_errors++;
      $display("FAIL idle_after_reset: got stb=%b busy=%b done=%b count=%0d full=%b, need zeros",
               tx_stb, busy, done, count, full);
    end
  endtask

  task automatic test_eof();
    int bad; logic [7:0] g, e;
    uart_bits = 3;
    pulse_start(16'h0000, 8'h01);
    load_str(":00000001FF");
    wait_record(bad, g, e);
    n_checks++;
    if (bad !== -1) begin
      n_errors++;
      $display("FAIL eof_seq: char %0d got %h need %h (%0d chars sent, need 13)", bad, g, e, rx_q.size());
    end
    n_checks++;
    if (done_cnt !== 1) begin
      n_errors++; $display("FAIL eof_done: got %0d pulses, need 1", done_cnt);
    end
    n_checks++;
    if (adj_cnt !== 0) begin
      n_errors++; $display("FAIL eof_spacing: got %0d adjacent strobes, need 0", adj_cnt);
    end
  endtask

  task automatic test_data();
    int bad; logic [7:0] g, e;
    uart_bits = 0;
    write_byte(8'h02); write_byte(8'h33); write_byte(8'h7A);
    n_checks++;
    if (count !== CW'(3)) begin
      n_errors++; $display("FAIL data_count: got %0d, need 3", count);
    end
    pulse_start(16'h0030, 8'h00);
    load_str(":0300300002337A1E");
    wait_record(bad, g, e);
    n_checks++;
    if (bad !== -1) begin
      n_errors++; $display("FAIL data_seq: char %0d got %h need %h", bad, g, e);
    end
    n_checks++;
    if (count !== '0 || done_cnt !== 1) begin
      n_errors++; $display("FAIL data_end: got count=%0d done=%0d, need count=0 done=1", count, done_cnt);
    end
    n_checks++;
    if (adj_cnt !== 0) begin
      n_errors++; $display("FAIL data_spacing: got %0d adjacent strobes, need 0", adj_cnt);
    end
  endtask

  task automatic test_full();
    int bad; logic [7:0] g, e;
    uart_bits = 1;
    for (int i = 0; i < MAX_LEN + 1; i++) write_byte(8'hFF);
    n_checks++;
    if (count !== CW'(MAX_LEN) || full !== 1'b1) begin
      n_errors++; $display("FAIL full_flags: got count=%0d full=%b, need 16 and 1", count, full);
    end
    build(16'hFFFF, 8'h00);
    pulse_start(16'hFFFF, 8'h00);
    wait_record(bad, g, e);
    n_checks++;
    if (bad !== -1) begin
      n_errors++; $display("FAIL full_seq: char %0d got %h need %h", bad, g, e);
    end
    n_checks++;
    if (exp_q.size() !== 45 || exp_q[exp_q.size()-4] !== 8'h30 || exp_q[exp_q.size()-3] !== 8'h32) begin
      n_errors++; $display("FAIL full_model: got %0d chars, need 45 ending in CC 02", exp_q.size());
    end
    n_checks++;
    if (count !== '0 || full !== 1'b0) begin
      n_errors++; $display("FAIL full_cleared: got count=%0d full=%b, need 0 and 0", count, full);
    end
  endtask

  task automatic test_random();
    int bad; logic [7:0] g, e; int len; logic [15:0] a; logic [7:0] t;
    for (int r = 0; r < 4; r++) begin
      uart_bits = $urandom_range(0, 12);
      len = $urandom_range(0, MAX_LEN);
      for (int i = 0; i < len; i++) write_byte(8'($urandom));
      a = 16'($urandom); t = 8'($urandom_range(0, 5));
      build(a, t);
      pulse_start(a, t);
      wait_record(bad, g, e);
      n_checks++;
      if (bad !== -1) begin
        n_errors++; $display("FAIL rand_seq[%0d]: len %0d char %0d got %h need %h", r, len, bad, g, e);
      end
      n_checks++;
      if (done_cnt !== 1 || count !== '0) begin
        n_errors++; $display("FAIL rand_end[%0d]: got done=%0d count=%0d, need 1 and 0", r, done_cnt, count);
      end
      n_checks++;
      if (adj_cnt !== 0) begin
        n_errors++; $display("FAIL rand_spacing[%0d]: got %0d adjacent strobes, need 0", r, adj_cnt);
      end
    end
  endtask

  task automatic test_backpressure();
    int bad; logic [7:0] g, e; int base;
    uart_bits = 2;
    for (int i = 0; i < 5; i++) write_byte(8'($urandom));
    build(16'h1234, 8'h00);
    pulse_start(16'h1234, 8'h00);
    wait_strobes(1);
    force_busy = 1'b1;
    base = stb_cnt;
    repeat (100) @(negedge clk);
    n_checks++;
    if (stb_cnt !== base) begin
      n_errors++; $display("FAIL bp_window: got %0d strobes while busy, need 0", stb_cnt - base);
    end
    force_busy = 1'b0;
    wait_record(bad, g, e);
    n_checks++;
    if (bad !== -1) begin
      n_errors++; $display("FAIL bp_seq: char %0d got %h need %h", bad, g, e);
    end
    n_checks++;
    if (adj_cnt !== 0 || done_cnt !== 1) begin
      n_errors++; $display("FAIL bp_end: got adjacent=%0d done=%0d, need 0 and 1", adj_cnt, done_cnt);
    end
  endtask

  task automatic test_busy_ignore();
    int bad; logic [7:0] g, e; int base;
    uart_bits = 4;
    write_byte(8'hA5); write_byte(8'h5A); write_byte(8'hC3);
    build(16'hBEEF, 8'h00);
    pulse_start(16'hBEEF, 8'h00);
    wait_strobes(10);
    @(negedge clk); start = 1'b1; addr = 16'h0F0F; typ = 8'h04; wr = 1'b1; wr_data = 8'h99;
    @(negedge clk); start = 1'b0; wr = 1'b0;
    wait_record(bad, g, e);
    n_checks++;
    if (bad !== -1) begin
      n_errors++; $display("FAIL ign_seq: char %0d got %h need %h", bad, g, e);
    end
    n_checks++;
    if (count !== '0 || done_cnt !== 1) begin
      n_errors++; $display("FAIL ign_end: got count=%0d done=%0d, need 0 and 1", count, done_cnt);
    end
    base = stb_cnt;
    repeat (40) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || stb_cnt !== base) begin
      n_errors++; $display("FAIL ign_no_restart: got busy=%b strobes=%0d, need 0 and 0", busy, stb_cnt - base);
    end
  endtask

  task automatic test_reset_mid();
    int bad; logic [7:0] g, e; int base;
    uart_bits = 3;
    for (int i = 0; i < 4; i++) write_byte(8'($urandom));
    pulse_start(16'h4000, 8'h00);
    wait_strobes(11);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({tx_stb, tx_data, busy, done, count, full} !== '0) begin
      n_errors++;
      $display("FAIL rst_mid_outputs: got stb=%b data=%h busy=%b done=%b count=%0d, need all zero",
               tx_stb, tx_data, busy, done, count);
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    base = stb_cnt;
    repeat (30) @(negedge clk);
    n_checks++;
    if (stb_cnt !== base || busy !== 1'b0) begin
      n_errors++; $display("FAIL rst_mid_resume: got %0d strobes busy=%b after reset, need 0 and 0", stb_cnt - base, busy);
    end
    model_buf = {};
    pulse_start(16'h0000, 8'h01);
    load_str(":00000001FF");
    wait_record(bad, g, e);
    n_checks++;
    if (bad !== -1 || done_cnt !== 1) begin
      n_errors++; $display("FAIL rst_mid_eof: char %0d got %h need %h, done=%0d need 1", bad, g, e, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_eof();
    test_data();
    test_full();
    test_random();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ihex_record_tx.md
# ihex_record_tx

Intel HEX record emitter: the transmit-side counterpart to the UART HEX-record receive path. It buffers up to MAX_LEN payload bytes, then on command serialises one complete ASCII record (`:LLAAAATT<data>CC` followed by CR LF) character by character into the existing `uart_tx` byte interface. It sits between the design's data source (memory dump, debug readout) and `uart_tx`, and drives its data and strobe inputs while honouring its busy flag.

## Interface
Parameters:
- MAX_LEN, default 16: payload buffer depth in bytes. Legal range 1..255.
- CW, default $clog2(MAX_LEN+1): width of the count port (derived, not overridden).

Ports:
- i_clk  in  1  clock; the single clock for all logic.
- i_rst_n  in  1  asynchronous active-low reset.
- i_wr  in  1  payload write strobe.
- i_wr_data  in  8  payload byte, sampled when i_wr is high.
- o_count  out  CW  number of bytes currently buffered.
- o_full  out  1  high when o_count == MAX_LEN.
- i_start  in  1  one-cycle request to emit a record.
- i_addr  in  16  record address, latched on an accepted i_start.
- i_type  in  8  record type, latched on an accepted i_start.
- o_busy  out  1  high while a record is being emitted.
- o_done  out  1  one-cycle pulse after the LF character has been strobed.
- o_tx_data  out  8  ASCII character for `uart_tx`.
- o_tx_stb  out  1  one-cycle strobe that loads o_tx_data into `uart_tx`.
- i_tx_busy  in  1  busy flag from `uart_tx`.

## Operation
Payload buffering:
- While idle, i_wr && !o_full stores i_wr_data at index o_count, and o_count increments.
- Writes are dropped when o_full is high or o_busy is high.
- On the same cycle in idle, i_start has priority over i_wr: the start is accepted and the write is dropped.

Record start:
- i_start is accepted only when idle. It is ignored while o_busy is high.
- An accepted start latches i_addr, i_type and LL = o_count. o_busy rises on the next edge.

Character sequence (13 + 2·LL characters in total):
- ':'
- LL, high nibble then low nibble.
- Address bits [15:12], [11:8], [7:4], [3:0].
- TT, high nibble then low nibble.
- Each payload byte, index 0 first, high nibble then low nibble.
- CC, high nibble then low nibble.
- 0x0D, then 0x0A.

Character encoding:
- Nibbles map to uppercase ASCII: 0–9 become 0x30–0x39, A–F become 0x41–0x46.

Checksum:
- CC = (−(LL + addr[15:8] + addr[7:0] + TT + Σdata)) mod 256.
- Accumulate in an 8-bit register with carries discarded. It is cleared on start and updated as each byte's high nibble is emitted.

FSM states:
- IDLE → COLON → LEN → ADDR → TYPE → DATA → CSUM → CR → LF → IDLE.
- A nibble-phase bit is used inside LEN, TYPE, DATA and CSUM.
- A 2-bit nibble index is used inside ADDR.
- A byte index is used inside DATA. With LL = 0, DATA is skipped entirely.

Completion:
- On leaving LF: o_busy falls, o_done pulses, and o_count returns to 0 (buffer emptied).

Reset:
- o_tx_stb = 0, o_tx_data = 0x00, o_busy = 0, o_done = 0, o_count = 0, o_full = 0, FSM = IDLE.
- Buffer contents are don't-care.
- Reset asserted mid-record aborts immediately: no further strobes are issued, and the partially sent record is not resumed.

## Timing
- i_start accepted at edge N. The ':' strobe occurs at edge N+1 at the earliest, provided i_tx_busy is low.
- A strobe is issued only in a cycle where i_tx_busy is low.
- After each strobe there is one mandatory guard cycle with no strobe, so that `uart_tx` can raise busy. i_tx_busy is evaluated again from the following cycle.
- Minimum spacing between strobes is 2 cycles. Real spacing is set by the UART bit time.
- o_tx_data is valid in the strobe cycle and holds until the next strobe.
- o_done pulses one cycle after the LF strobe. A new i_start is accepted on that same cycle.
- i_tx_busy held high stalls the FSM indefinitely. Sequence content is unaffected.
- o_count and o_full are registered and update one cycle after the accepted write.

## Test plan
- EOF record: empty buffer, i_start with addr 0x0000, type 0x01 → strobed sequence ":00000001FF" CR LF (13 characters), then a single o_done pulse.
- Data record: write 0x02, 0x33, 0x7A; start with addr 0x0030, type 0x00 → ":0300300002337A1E" CR LF; o_count is 0 afterwards.
- Full buffer: 17 writes of 0xFF → o_count = 16 and o_full = 1 (17th write dropped). Start with addr 0xFFFF, type 0x00 → LL "10", 32 'F' data characters, CC "02".
- Backpressure: i_tx_busy forced high for 100 cycles after ':' → zero strobes during that window; the final sequence is identical to the unstalled run; no two strobes occur in adjacent cycles.
- Start and write while busy: i_start and i_wr pulsed mid-record → the record is unchanged; the second start is ignored; no new byte is buffered; o_count = 0 after o_done.
- Reset mid-record: assert i_rst_n low during DATA → outputs go to their reset values immediately. After release, a fresh EOF record emits a correct 13-character sequence.
